// File: rtl/ud_ctrl_pkg.sv
// Shared types and constants for the up/down step controller.
package ud_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/ud_modn_tcount.sv
// Modulo-MOD up/down counter built from T flip-flops. Each bit toggles when
// its T input is high; T inputs are only non-zero on a preset or an enabled
// step, so the value never changes otherwise and never leaves 0..MOD-1.
module ud_modn_tcount #(
    parameter int MOD = 6,
    localparam int QW = $clog2(MOD)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          dir,
    input  logic          load,
    input  logic [QW-1:0] load_val,
    output logic [QW-1:0] q,
    output logic          wrap
);
    import ud_ctrl_pkg::*;

    localparam logic [QW-1:0] ZERO_Q = QW'(0);
    localparam logic [QW-1:0] ONE_Q  = QW'(1);
    localparam logic [QW-1:0] MAX_Q  = QW'(MOD - 1);
    localparam logic [QW:0]   MOD_V  = (QW + 1)'(MOD);

    logic [QW-1:0] q_r;
    logic [QW-1:0] nxt_s;
    logic [QW-1:0] tgt_s;
    logic [QW-1:0] t_s;
    logic          edge_s;
    logic          wrap_r;

    // Value one step away in the requested direction, flagging the wrap point.
    always_comb begin
        nxt_s  = q_r;
        edge_s = 1'b0;
        if (dir == DIR_UP) begin
            if (q_r >= MAX_Q) begin
                nxt_s  = ZERO_Q;
                edge_s = 1'b1;
            end else begin
                nxt_s  = q_r + ONE_Q;
            end
        end else begin
            if (q_r == ZERO_Q) begin
                nxt_s  = MAX_Q;
                edge_s = 1'b1;
            end else begin
                nxt_s  = q_r - ONE_Q;
            end
        end
    end

    // Out-of-range presets collapse to zero so the counter stays in range.
    always_comb begin
        tgt_s = ZERO_Q;
        if ({1'b0, load_val} < MOD_V) begin
            tgt_s = load_val;
        end else begin
            tgt_s = ZERO_Q;
        end
    end

    // Toggle inputs: preset wins over stepping; nothing toggles otherwise.
    always_comb begin
        t_s = ZERO_Q;
        if (load) begin
            t_s = q_r ^ tgt_s;
        end else if (en) begin
            t_s = q_r ^ nxt_s;
        end else begin
            t_s = ZERO_Q;
        end
    end

    // T flip-flop bank: each bit flips where its toggle input is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r <= ZERO_Q;
        end else begin
            q_r <= q_r ^ t_s;
        end
    end

    // One-cycle wrap pulse on a step that crosses the modulus boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= ~load & en & edge_s;
        end
    end

    assign q    = q_r;
    assign wrap = wrap_r;

endmodule

// File: rtl/ud_step_ctrl.sv
// Command-driven sequencer that owns the modulo-MOD counter: accepts a move
// command (optional preset, direction, step count), steps once per unpaused
// cycle, supports abort, and reports completion with a one-cycle done pulse.
module ud_step_ctrl #(
    parameter int MOD = 6,
    parameter int CW  = 4,
    localparam int QW = $clog2(MOD)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_dir,
    input  logic [CW-1:0] cmd_steps,
    input  logic          cmd_load,
    input  logic [QW-1:0] cmd_value,
    input  logic          pause,
    input  logic          abort,
    output logic [QW-1:0] q,
    output logic          busy,
    output logic          done,
    output logic          wrap,
    output logic [CW-1:0] remaining,
    output logic          load_err
);
    import ud_ctrl_pkg::*;

    localparam logic [QW:0]   MOD_V   = (QW + 1)'(MOD);
    localparam logic [CW-1:0] ZERO_C  = CW'(0);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    state_t        state_r;
    state_t        next_state_s;
    logic [CW-1:0] remaining_r;
    logic          dir_r;
    logic          busy_r;
    logic          done_r;
    logic          ready_r;
    logic          load_err_r;
    logic          accept_s;
    logic          step_s;
    logic          load_s;
    logic          load_bad_s;

    assign accept_s   = cmd_valid & (state_r == IDLE);
    assign step_s     = (state_r == RUN) & ~abort & ~pause;
    assign load_s     = accept_s & cmd_load;
    assign load_bad_s = load_s & ({1'b0, cmd_value} >= MOD_V);

    // Next-state logic: abort beats pause, last step leads to DONE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (cmd_steps == ZERO_C) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = RUN;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    next_state_s = IDLE;
                end else if (step_s && (remaining_r == ONE_C)) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register plus status outputs registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == RUN);
            done_r  <= (next_state_s == DONE);
            ready_r <= (next_state_s == IDLE);
        end
    end

    // Remaining-step counter and latched direction for the active command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining_r <= ZERO_C;
            dir_r       <= DIR_UP;
        end else if (accept_s) begin
            remaining_r <= cmd_steps;
            dir_r       <= cmd_dir;
        end else if ((state_r == RUN) && abort) begin
            remaining_r <= ZERO_C;
        end else if (step_s) begin
            remaining_r <= remaining_r - ONE_C;
        end else begin
            remaining_r <= remaining_r;
        end
    end

    // One-cycle pulse when an accepted preset was out of range.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_err_r <= 1'b0;
        end else begin
            load_err_r <= load_bad_s;
        end
    end

    ud_modn_tcount #(.MOD(MOD)) u_count (
        .clk      (clk),
        .reset    (reset),
        .en       (step_s),
        .dir      (dir_r),
        .load     (load_s),
        .load_val (cmd_value),
        .q        (q),
        .wrap     (wrap)
    );

    assign cmd_ready = ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign remaining = remaining_r;
    assign load_err  = load_err_r;

endmodule

// File: tb/tb_ud_step_ctrl.sv
// Self-checking bench for ud_step_ctrl: a behavioural model pushes expected
// outputs into a scoreboard queue as each cycle is driven; they are popped
// and compared against the DUT after the clock edge.
module tb_ud_step_ctrl;

    localparam int MOD = 6;
    localparam int CW  = 4;
    localparam int QW  = $clog2(MOD);

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_dir;
    logic [CW-1:0] cmd_steps;
    logic          cmd_load;
    logic [QW-1:0] cmd_value;
    logic          pause;
    logic          abort;
    logic [QW-1:0] q;
    logic          busy;
    logic          done;
    logic          wrap;
    logic [CW-1:0] remaining;
    logic          load_err;

    typedef struct {
        int q;
        int rem;
        int busy;
        int done;
        int wrap;
        int ready;
        int lerr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // model state: 0 idle, 1 run, 2 done
    int m_state = 0;
    int m_q     = 0;
    int m_rem   = 0;
    int m_dir   = 1;

    ud_step_ctrl #(.MOD(MOD), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_steps (cmd_steps),
        .cmd_load  (cmd_load),
        .cmd_value (cmd_value),
        .pause     (pause),
        .abort     (abort),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap),
        .remaining (remaining),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_q     = 0;
        m_rem   = 0;
        m_dir   = 1;
    endtask

    // Drive one clock with current inputs; model predicts, DUT is compared.
    task automatic step_cycle();
        exp_t e;
        int   nst;
        int   nq;
        int   nrem;
        nst    = m_state;
        nq     = m_q;
        nrem   = m_rem;
        e.wrap = 0;
        e.lerr = 0;
        case (m_state)
            0: begin
                if (cmd_valid) begin
                    m_dir = int'(cmd_dir);
                    nrem  = int'(cmd_steps);
                    if (cmd_load) begin
                        if (int'(cmd_value) < MOD) nq = int'(cmd_value);
                        else begin
                            nq     = 0;
                            e.lerr = 1;
                        end
                    end
                    nst = (cmd_steps == 0) ? 2 : 1;
                end
            end
            1: begin
                if (abort) begin
                    nst  = 0;
                    nrem = 0;
                end else if (!pause) begin
                    if (m_dir == 1) begin
                        nq     = (m_q + 1) % MOD;
                        e.wrap = (m_q == MOD - 1) ? 1 : 0;
                    end else begin
                        nq     = (m_q + MOD - 1) % MOD;
                        e.wrap = (m_q == 0) ? 1 : 0;
                    end
                    nrem = m_rem - 1;
                    if (m_rem == 1) nst = 2;
                end
            end
            default: nst = 0;
        endcase
        m_state = nst;
        m_q     = nq;
        m_rem   = nrem;
        e.q     = nq;
        e.rem   = nrem;
        e.busy  = (nst == 1) ? 1 : 0;
        e.done  = (nst == 2) ? 1 : 0;
        e.ready = (nst == 0) ? 1 : 0;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check_eq("q", int'(q), e.q);
        check_eq("remaining", int'(remaining), e.rem);
        check_eq("busy", int'(busy), e.busy);
        check_eq("done", int'(done), e.done);
        check_eq("wrap", int'(wrap), e.wrap);
        check_eq("cmd_ready", int'(cmd_ready), e.ready);
        check_eq("load_err", int'(load_err), e.lerr);
    endtask

    // Issue one command and run until the block is ready again (bounded).
    task automatic run_cmd(input int dir, input int steps, input int ld, input int val,
                           input int p0, input int plen, input int a0,
                           output int done_idx, output int wraps);
        done_idx  = -1;
        wraps     = 0;
        cmd_valid = 1'b1;
        cmd_dir   = 1'(dir);
        cmd_steps = CW'(steps);
        cmd_load  = 1'(ld);
        cmd_value = QW'(val);
        pause     = 1'b0;
        abort     = 1'b0;
        step_cycle();
        if (done) done_idx = 0;
        if (wrap) wraps++;
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        for (int i = 1; i < 40; i++) begin
            if (cmd_ready) break;
            pause = (i >= p0 && i < p0 + plen) ? 1'b1 : 1'b0;
            abort = (i == a0) ? 1'b1 : 1'b0;
            step_cycle();
            if (done) done_idx = i;
            if (wrap) wraps++;
        end
        pause = 1'b0;
        abort = 1'b0;
        check_eq("back_to_idle", int'(cmd_ready), 1);
    endtask

    initial begin
        int didx;
        int wr;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_steps = '0;
        cmd_load  = 1'b0;
        cmd_value = '0;
        pause     = 1'b0;
        abort     = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_q", int'(q), 0);
        check_eq("rst_ready", int'(cmd_ready), 1);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_remaining", int'(remaining), 0);
        check_eq("rst_wrap", int'(wrap), 0);
        check_eq("rst_load_err", int'(load_err), 0);
        reset = 1'b0;
        model_reset();
        step_cycle();

        // up 8 from 0: 1,2,3,4,5,0,1,2
        run_cmd(1, 8, 0, 0, 99, 0, 99, didx, wr);
        check_eq("up8_done_idx", didx, 8);
        check_eq("up8_wraps", wr, 1);
        check_eq("up8_final_q", int'(q), 2);

        // preset 3, down 5: 3,2,1,0,5,4
        run_cmd(0, 5, 1, 3, 99, 0, 99, didx, wr);
        check_eq("dn5_done_idx", didx, 5);
        check_eq("dn5_wraps", wr, 1);
        check_eq("dn5_final_q", int'(q), 4);

        // preset 0, up 4 with pause during edges 3..5
        run_cmd(1, 4, 1, 0, 3, 3, 99, didx, wr);
        check_eq("pause_done_idx", didx, 7);
        check_eq("pause_final_q", int'(q), 4);

        // preset 0, up 10, abort at edge 3 (after two steps)
        run_cmd(1, 10, 1, 0, 99, 0, 3, didx, wr);
        check_eq("abort_no_done", didx, -1);
        check_eq("abort_q", int'(q), 2);
        check_eq("abort_remaining", int'(remaining), 0);
        check_eq("abort_busy", int'(busy), 0);

        // immediate next command: down 2 from 2
        run_cmd(0, 2, 0, 0, 99, 0, 99, didx, wr);
        check_eq("after_abort_done_idx", didx, 2);
        check_eq("after_abort_q", int'(q), 0);

        // out-of-range preset with zero steps
        run_cmd(1, 0, 1, 7, 99, 0, 99, didx, wr);
        check_eq("lerr_done_idx", didx, 0);
        check_eq("lerr_q", int'(q), 0);

        // abort together with pause: abort wins
        run_cmd(1, 6, 1, 1, 2, 4, 3, didx, wr);
        check_eq("abort_pause_no_done", didx, -1);
        check_eq("abort_pause_q", int'(q), 2);

        // async reset mid-RUN, between edges
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_steps = CW'(10);
        cmd_load  = 1'b1;
        cmd_value = QW'(4);
        step_cycle();
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        step_cycle();
        #2;
        reset = 1'b1;
        #1;
        check_eq("midrst_q", int'(q), 0);
        check_eq("midrst_ready", int'(cmd_ready), 1);
        check_eq("midrst_busy", int'(busy), 0);
        check_eq("midrst_done", int'(done), 0);
        check_eq("midrst_remaining", int'(remaining), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (2) step_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
